// File: rtl/router_pkg.sv
// Shared definitions for the virtual-channel router: FSM encodings and default sizing.
package router_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam int DEF_BITNUMBER  = 6;
    localparam int DEF_NUM_VC     = 2;
    localparam int DEF_VC_LSB     = 5;
    localparam int DEF_NUM_DEST   = 2;
    localparam int DEF_D_LSB      = 4;
    localparam int DEF_MAIN_DEPTH = 8;
    localparam int DEF_VC_DEPTH   = 16;
    localparam int DEF_D_DEPTH    = 4;
    localparam int DEF_TH_W       = 4;

endpackage

// File: rtl/fifo_flops.sv
// Flop-based FIFO with occupancy count and a programmable almost-full threshold.
module fifo_flops #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6,
    parameter int TH_W  = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [TH_W-1:0]  i_umbral,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_almost_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_rd;
    logic             w_wr;

    assign o_count   = r_count;
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_rd_data = r_mem[r_rd_ptr];
    // A zero threshold disables almost-full so the FIFO only blocks when completely full.
    assign o_almost_full = (i_umbral != '0) && (32'(r_count) >= 32'(i_umbral));

    // A read frees a slot in the same cycle, so a full FIFO may accept a concurrent write.
    assign w_rd = i_rd_en && !o_empty;
    assign w_wr = i_wr_en && (!o_full || w_rd);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/vc_router_param.sv
// Main FIFO -> per-VC FIFOs -> per-destination FIFOs, with threshold-based back-pressure
// and a control FSM that blocks all movement in RESET and ERROR.
module vc_router_param
    import router_pkg::*;
#(
    parameter int BITNUMBER  = DEF_BITNUMBER,
    parameter int NUM_VC     = DEF_NUM_VC,
    parameter int VC_LSB     = DEF_VC_LSB,
    parameter int NUM_DEST   = DEF_NUM_DEST,
    parameter int D_LSB      = DEF_D_LSB,
    parameter int MAIN_DEPTH = DEF_MAIN_DEPTH,
    parameter int VC_DEPTH   = DEF_VC_DEPTH,
    parameter int D_DEPTH    = DEF_D_DEPTH,
    parameter int TH_W       = DEF_TH_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          init,
    input  logic [TH_W-1:0]               umbral_main,
    input  logic [TH_W-1:0]               umbral_vc,
    input  logic [TH_W-1:0]               umbral_d,
    input  logic                          push,
    input  logic [BITNUMBER-1:0]          data_in,
    input  logic [NUM_DEST-1:0]           pop,
    output logic [NUM_DEST*BITNUMBER-1:0] data_out,
    output logic [NUM_DEST-1:0]           valid_out,
    output logic [NUM_DEST-1:0]           d_can_pop,
    output logic                          main_pause,
    output logic [2:0]                    state,
    output logic                          error
);

    localparam int VCW = $clog2(NUM_VC);
    localparam int DW  = $clog2(NUM_DEST);
    localparam int MCW = $clog2(MAIN_DEPTH) + 1;
    localparam int VCC = $clog2(VC_DEPTH) + 1;
    localparam int DCW = $clog2(D_DEPTH) + 1;

    state_t                          r_state;
    logic                            r_error;
    logic [TH_W-1:0]                 r_um_main;
    logic [TH_W-1:0]                 r_um_vc;
    logic [TH_W-1:0]                 r_um_d;
    logic [NUM_DEST*BITNUMBER-1:0]   r_data_out;
    logic [NUM_DEST-1:0]             r_valid_out;

    logic                            w_run;
    logic                            w_any;
    logic                            w_err_evt;

    logic                            w_main_wr;
    logic                            w_main_rd;
    logic [BITNUMBER-1:0]            w_main_head;
    logic [MCW-1:0]                  w_main_count;
    logic                            w_main_full;
    logic                            w_main_empty;
    logic                            w_main_af;
    logic [VCW-1:0]                  w_head_vc;

    logic [NUM_VC-1:0]               w_vc_wr;
    logic [NUM_VC-1:0]               w_vc_rd;
    logic [BITNUMBER-1:0]            w_vc_head [NUM_VC];
    logic [VCC-1:0]                  w_vc_count [NUM_VC];
    logic [NUM_VC-1:0]               w_vc_full;
    logic [NUM_VC-1:0]               w_vc_empty;
    logic [NUM_VC-1:0]               w_vc_af;
    logic [DW-1:0]                   w_vc_dest [NUM_VC];
    logic [NUM_VC-1:0]               w_vc_ok;

    logic                            w_xfer;
    logic [VCW-1:0]                  w_sel_vc;
    logic [DW-1:0]                   w_sel_dest;
    logic [BITNUMBER-1:0]            w_xfer_data;

    logic [NUM_DEST-1:0]             w_d_wr;
    logic [NUM_DEST-1:0]             w_d_rd;
    logic [BITNUMBER-1:0]            w_d_head [NUM_DEST];
    logic [DCW-1:0]                  w_d_count [NUM_DEST];
    logic [NUM_DEST-1:0]             w_d_full;
    logic [NUM_DEST-1:0]             w_d_empty;
    logic [NUM_DEST-1:0]             w_d_af;

    assign w_run = (r_state != ST_RESET) && (r_state != ST_ERROR);

    // Push into main; a push against a full main FIFO is dropped and flagged.
    assign w_main_wr = w_run && push && !w_main_full;

    fifo_flops #(.DEPTH(MAIN_DEPTH), .WIDTH(BITNUMBER), .TH_W(TH_W)) u_main (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_wr_en       (w_main_wr),
        .i_wr_data     (data_in),
        .i_rd_en       (w_main_rd),
        .i_umbral      (r_um_main),
        .o_rd_data     (w_main_head),
        .o_count       (w_main_count),
        .o_full        (w_main_full),
        .o_empty       (w_main_empty),
        .o_almost_full (w_main_af)
    );

    // The main head stalls whenever its VC cannot take it, blocking everything behind it.
    assign w_head_vc = w_main_head[VC_LSB +: VCW];
    assign w_main_rd = w_run && !w_main_empty && !w_vc_full[w_head_vc] && !w_vc_af[w_head_vc];

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign w_vc_wr[v]   = w_main_rd && (w_head_vc == VCW'(v));
        assign w_vc_rd[v]   = w_xfer && (w_sel_vc == VCW'(v));
        assign w_vc_dest[v] = w_vc_head[v][D_LSB +: DW];
        assign w_vc_ok[v]   = !w_vc_empty[v] && !w_d_full[w_vc_dest[v]] && !w_d_af[w_vc_dest[v]];

        fifo_flops #(.DEPTH(VC_DEPTH), .WIDTH(BITNUMBER), .TH_W(TH_W)) u_vc (
            .i_clk         (clk),
            .i_reset       (reset),
            .i_wr_en       (w_vc_wr[v]),
            .i_wr_data     (w_main_head),
            .i_rd_en       (w_vc_rd[v]),
            .i_umbral      (r_um_vc),
            .o_rd_data     (w_vc_head[v]),
            .o_count       (w_vc_count[v]),
            .o_full        (w_vc_full[v]),
            .o_empty       (w_vc_empty[v]),
            .o_almost_full (w_vc_af[v])
        );
    end

    // Fixed priority: scanning downward lets the lowest eligible VC index win.
    always_comb begin
        w_xfer   = 1'b0;
        w_sel_vc = '0;
        for (int v = NUM_VC - 1; v >= 0; v--) begin
            if (w_vc_ok[v]) begin
                w_xfer   = w_run;
                w_sel_vc = VCW'(v);
            end
        end
    end

    assign w_sel_dest  = w_vc_dest[w_sel_vc];
    assign w_xfer_data = w_vc_head[w_sel_vc];

    for (genvar d = 0; d < NUM_DEST; d++) begin : g_dest
        assign w_d_wr[d] = w_xfer && (w_sel_dest == DW'(d));
        assign w_d_rd[d] = w_run && pop[d] && !w_d_empty[d];

        fifo_flops #(.DEPTH(D_DEPTH), .WIDTH(BITNUMBER), .TH_W(TH_W)) u_d (
            .i_clk         (clk),
            .i_reset       (reset),
            .i_wr_en       (w_d_wr[d]),
            .i_wr_data     (w_xfer_data),
            .i_rd_en       (w_d_rd[d]),
            .i_umbral      (r_um_d),
            .o_rd_data     (w_d_head[d]),
            .o_count       (w_d_count[d]),
            .o_full        (w_d_full[d]),
            .o_empty       (w_d_empty[d]),
            .o_almost_full (w_d_af[d])
        );
    end

    always_comb begin
        w_any = (w_main_count != '0);
        for (int v = 0; v < NUM_VC; v++) w_any = w_any || (w_vc_count[v] != '0);
        for (int d = 0; d < NUM_DEST; d++) w_any = w_any || (w_d_count[d] != '0);
    end

    assign w_err_evt = w_run && ((push && w_main_full) || ((pop & w_d_empty) != '0));

    // Registered read port: valid pulses for one cycle, data holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out  <= '0;
            r_valid_out <= '0;
        end else begin
            for (int d = 0; d < NUM_DEST; d++) begin
                r_valid_out[d] <= w_d_rd[d];
                if (w_d_rd[d]) r_data_out[d*BITNUMBER +: BITNUMBER] <= w_d_head[d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_RESET;
            r_error   <= 1'b0;
            r_um_main <= '0;
            r_um_vc   <= '0;
            r_um_d    <= '0;
        end else begin
            if (w_err_evt) r_error <= 1'b1;
            if (w_err_evt || r_error) begin
                r_state <= ST_ERROR;
            end else begin
                case (r_state)
                    ST_RESET: r_state <= ST_INIT;
                    ST_INIT: begin
                        if (init) begin
                            r_um_main <= umbral_main;
                            r_um_vc   <= umbral_vc;
                            r_um_d    <= umbral_d;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_IDLE, ST_ACTIVE: begin
                        if (init)       r_state <= ST_INIT;
                        else if (w_any) r_state <= ST_ACTIVE;
                        else            r_state <= ST_IDLE;
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign main_pause = w_main_af || w_main_full || (w_vc_af != '0) || (w_vc_full != '0);
    assign d_can_pop  = ~w_d_empty;
    assign data_out   = r_data_out;
    assign valid_out  = r_valid_out;
    assign state      = r_state;
    assign error      = r_error;

endmodule

// File: tb/tb_vc_router_param.sv
// Scoreboard bench for vc_router_param: expected words are queued per (VC, destination) flow on push.
module tb_vc_router_param;

    localparam int BW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          init;
    logic [3:0]    umbral_main;
    logic [3:0]    umbral_vc;
    logic [3:0]    umbral_d;
    logic          push;
    logic [BW-1:0] data_in;
    logic [1:0]    pop;
    logic [2*BW-1:0] data_out;
    logic [1:0]    valid_out;
    logic [1:0]    d_can_pop;
    logic          main_pause;
    logic [2:0]    state;
    logic          error;

    int n_checks = 0;
    int n_errors = 0;
    logic [BW-1:0] sb_q [4][$];

    vc_router_param dut (
        .clk         (clk),
        .reset       (reset),
        .init        (init),
        .umbral_main (umbral_main),
        .umbral_vc   (umbral_vc),
        .umbral_d    (umbral_d),
        .push        (push),
        .data_in     (data_in),
        .pop         (pop),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .d_can_pop   (d_can_pop),
        .main_pause  (main_pause),
        .state       (state),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [BW-1:0] w, input bit record);
        push    = 1'b1;
        data_in = w;
        step();
        push    = 1'b0;
        if (record) sb_q[{w[5], w[4]}].push_back(w);
    endtask

    task automatic wait_can_pop(input int d, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (d_can_pop[d]) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) chk_eq("can_pop_timeout", 32'd0, 32'd1);
    endtask

    task automatic pop_dest(input int d, output logic [BW-1:0] got);
        int fl;
        pop    = '0;
        pop[d] = 1'b1;
        step();
        pop = '0;
        got = data_out[d*BW +: BW];
        chk_eq("pop_valid", 32'(valid_out[d]), 32'd1);
        chk_eq("pop_dest_bit", 32'(got[4]), 32'(d));
        fl = int'({got[5], got[4]});
        if (sb_q[fl].size() == 0) chk_eq("pop_unexpected", 32'(got), 32'hFFFF);
        else chk_eq("pop_data", 32'(got), 32'(sb_q[fl].pop_front()));
    endtask

    task automatic load_thresholds(input logic [3:0] m, input logic [3:0] v, input logic [3:0] d);
        init        = 1'b1;
        umbral_main = m;
        umbral_vc   = v;
        umbral_d    = d;
        if (state != 3'd1) step();
        step();
        init        = 1'b0;
        umbral_main = '0;
        umbral_vc   = '0;
        umbral_d    = '0;
        step();
    endtask

    initial begin
        logic [BW-1:0] got;
        bit ok;
        bit saw_pause;
        int drained;

        reset = 1'b1; init = 1'b0; push = 1'b0; pop = '0; data_in = '0;
        umbral_main = '0; umbral_vc = '0; umbral_d = '0;
        step();
        step();
        chk_eq("rst_state", 32'(state), 32'd0);
        chk_eq("rst_pause", 32'(main_pause), 32'd0);
        chk_eq("rst_can_pop", 32'(d_can_pop), 32'd0);
        chk_eq("rst_valid", 32'(valid_out), 32'd0);
        chk_eq("rst_data", 32'(data_out), 32'd0);
        chk_eq("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        step();
        chk_eq("state_init", 32'(state), 32'd1);

        // Threshold load, then prove the latched main threshold with zeroed inputs.
        init = 1'b1; umbral_main = 4'd1; umbral_vc = 4'd3; umbral_d = 4'd1;
        step();
        chk_eq("init_hold", 32'(state), 32'd1);
        init = 1'b0; umbral_main = '0; umbral_vc = '0; umbral_d = '0;
        step();
        chk_eq("state_idle", 32'(state), 32'd2);
        push_word(6'h10, 1'b1);
        chk_eq("pause_th_main", 32'(main_pause), 32'd1);
        push_word(6'h05, 1'b1);
        chk_eq("state_active", 32'(state), 32'd3);

        // Routing by destination bit.
        wait_can_pop(1, ok);
        wait_can_pop(0, ok);
        pop_dest(1, got);
        chk_eq("route_d1", 32'(got), 32'h10);
        step();
        chk_eq("valid_drop", 32'(valid_out[1]), 32'd0);
        chk_eq("data_hold", 32'(data_out[BW +: BW]), 32'h10);
        pop_dest(0, got);
        chk_eq("route_d0", 32'(got), 32'h05);
        repeat (3) step();
        chk_eq("state_back_idle", 32'(state), 32'd2);

        // Priority: dest0 holds one word (threshold 1) so VC1 and VC0 heads contend.
        push_word(6'h00, 1'b1);
        push_word(6'h21, 1'b1);
        push_word(6'h05, 1'b1);
        repeat (6) step();
        wait_can_pop(0, ok);
        pop_dest(0, got);
        chk_eq("prio_first_resident", 32'(got), 32'h00);
        wait_can_pop(0, ok);
        pop_dest(0, got);
        chk_eq("prio_vc0_wins", 32'(got), 32'h05);
        wait_can_pop(0, ok);
        pop_dest(0, got);
        chk_eq("prio_vc1_next", 32'(got), 32'h21);
        repeat (3) step();

        // Pause: 16 words to VC0/dest0 with pops held fill dest, VC and main exactly.
        load_thresholds(4'd6, 4'd4, 4'd0);
        chk_eq("reinit_idle", 32'(state), 32'd2);
        saw_pause = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push_word(BW'(i), 1'b1);
            if (main_pause) saw_pause = 1'b1;
        end
        repeat (5) step();
        chk_eq("pause_seen", 32'(saw_pause), 32'd1);
        chk_eq("pause_end", 32'(main_pause), 32'd1);
        chk_eq("pause_no_err", 32'(error), 32'd0);
        drained = 0;
        for (int k = 0; k < 40 && sb_q[0].size() > 0; k++) begin
            wait_can_pop(0, ok);
            if (!ok) break;
            pop_dest(0, got);
            drained++;
        end
        chk_eq("pause_drained", 32'(drained), 32'd16);
        repeat (3) step();
        chk_eq("pause_release", 32'(main_pause), 32'd0);

        // Pop on an empty destination is sticky until reset, and blocks pushes.
        pop = 2'b10;
        step();
        pop = '0;
        chk_eq("err_pop_flag", 32'(error), 32'd1);
        chk_eq("err_pop_state", 32'(state), 32'd4);
        push_word(6'h07, 1'b0);
        repeat (2) step();
        chk_eq("err_sticky", 32'(state), 32'd4);
        chk_eq("err_push_blocked", 32'(d_can_pop), 32'd0);

        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk_eq("rerst_init", 32'(state), 32'd1);
        load_thresholds(4'd6, 4'd4, 4'd0);

        // Push into a full main FIFO.
        for (int i = 0; i < 16; i++) push_word(BW'(i), 1'b1);
        repeat (5) step();
        chk_eq("full_no_err", 32'(error), 32'd0);
        push_word(6'h0F, 1'b0);
        chk_eq("err_full_flag", 32'(error), 32'd1);
        chk_eq("err_full_state", 32'(state), 32'd4);

        // Reset wins over push, pop and init with data queued.
        reset = 1'b1; push = 1'b1; pop = 2'b11; init = 1'b1;
        step();
        chk_eq("midrst_can_pop", 32'(d_can_pop), 32'd0);
        chk_eq("midrst_pause", 32'(main_pause), 32'd0);
        chk_eq("midrst_state", 32'(state), 32'd0);
        chk_eq("midrst_valid", 32'(valid_out), 32'd0);
        chk_eq("midrst_error", 32'(error), 32'd0);
        chk_eq("midrst_data", 32'(data_out), 32'd0);
        for (int f = 0; f < 4; f++) sb_q[f].delete();
        reset = 1'b0; push = 1'b0; pop = '0; init = 1'b0;
        step();
        chk_eq("midrst_init", 32'(state), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
